audio_dac_frame_receiver: RTL and testbench

Serial responder for the 24-bit dual-DAC write frame driven by our DAC writer: SYNC (active-low frame), SCLK (idle high), DIN (changes on SCLK rise, sampled on SCLK fall), MSB first. It oversamples the three lines on the system clock and decodes each frame into command, address and data fields. It also models the DAC input and output registers for A and B, plus the LDAC and CLR pins. It serves as the loopback monitor and emulation target for the DAC datapath.

---
 rtl/audio_dac_frame_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_audio_dac_frame_receiver.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_frame_receiver.sv
// audio_dac_frame_receiver: decodes 24-bit dual-DAC write frames (SYNC/SCLK/DIN)
// oversampled on clk, and models the DAC A/B input and output registers together
// with the LDAC (load) and CLR (clear) pins.
//
// Handshake note: there is no valid/ready flow control here. frame_valid and
// frame_error are single-cycle pulses with no back-pressure. cmd/addr/data hold
// the fields of the last well-formed frame until the next one replaces them.
module audio_dac_frame_receiver #(
  parameter int          FRAME_BITS  = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] CLR_VALUE   = 16'h0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        SCLK,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic        LDAC,
  input  logic        CLR,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [2:0]  cmd,
  output logic [2:0]  addr,
  output logic [15:0] data,
  output logic [15:0] DAC_A,
  output logic [15:0] DAC_B,
  output logic        dac_update,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic [15:0] dbg_in_a,
  output logic [15:0] dbg_in_b
);

  localparam logic [1:0] S_WAIT_HIGH = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_SHIFT     = 2'd2;
  localparam logic [1:0] S_COMMIT    = 2'd3;

  // The two leading frame bits are don't-care and fall off the top of the
  // shift register, so only the decoded field bits are kept.
  localparam int FIELD_BITS = 22;

  logic [SYNC_STAGES-1:0] sclk_sr, sync_sr, din_sr, ldac_sr, clr_sr;
  logic                   sclk_d, sync_d;
  logic [SYNC_STAGES:0]   warm;
  logic [1:0]             state;
  logic [4:0]             count;
  logic [FIELD_BITS-1:0]  shreg;
  logic [15:0]            in_a, in_b;

  logic sclk_s, sync_s, din_s, ldac_s, clr_s;
  logic sclk_fall, sync_fall, sync_rise;
  logic frame_ok, frame_bad;
  logic [2:0]  f_cmd, f_addr;
  logic [15:0] f_data;
  logic hit_a, hit_b;
  logic [15:0] in_a_n, in_b_n, dac_a_n, dac_b_n;

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign sync_s    = sync_sr[SYNC_STAGES-1];
  assign din_s     = din_sr[SYNC_STAGES-1];
  assign ldac_s    = ldac_sr[SYNC_STAGES-1];
  assign clr_s     = clr_sr[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sync_fall = sync_d & ~sync_s;
  assign sync_rise = ~sync_d & sync_s;

  assign f_cmd  = shreg[21:19];
  assign f_addr = shreg[18:16];
  assign f_data = shreg[15:0];

  assign frame_ok  = (state == S_COMMIT) && (count == 5'(FRAME_BITS));
  assign frame_bad = (state == S_COMMIT) && (count != 5'(FRAME_BITS));

  assign busy      = (state == S_SHIFT);
  assign dbg_state = state;
  assign dbg_in_a  = in_a;
  assign dbg_in_b  = in_b;

  // Identical synchronizer chains keep DIN aligned with SCLK. The warm-up
  // shifter proves the chains hold real pin values rather than the preset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sr <= '1;
      sync_sr <= '1;
      din_sr  <= '1;
      ldac_sr <= '1;
      clr_sr  <= '1;
      sclk_d  <= 1'b1;
      sync_d  <= 1'b1;
      warm    <= '0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], SCLK};
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], SYNC};
      din_sr  <= {din_sr[SYNC_STAGES-2:0], DIN};
      ldac_sr <= {ldac_sr[SYNC_STAGES-2:0], LDAC};
      clr_sr  <= {clr_sr[SYNC_STAGES-2:0], CLR};
      sclk_d  <= sclk_s;
      sync_d  <= sync_s;
      warm    <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame FSM: wait for a clean SYNC high, then shift bits between SYNC edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_WAIT_HIGH;
      count <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_WAIT_HIGH: if (warm[SYNC_STAGES] && sync_s) state <= S_IDLE;
        S_IDLE: begin
          count <= '0;
          if (sync_fall) state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (sync_rise) begin
            state <= S_COMMIT;
          end else if (sclk_fall) begin
            shreg <= {shreg[FIELD_BITS-2:0], din_s};
            if (count != 5'd31) count <= count + 5'd1;
          end
        end
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_WAIT_HIGH;
      endcase
    end
  end

  // Next values of the DAC register model: command first, then LDAC, then CLR.
  always_comb begin
    in_a_n  = in_a;
    in_b_n  = in_b;
    dac_a_n = DAC_A;
    dac_b_n = DAC_B;
    hit_a   = (f_addr == 3'b000) || (f_addr == 3'b111);
    hit_b   = (f_addr == 3'b001) || (f_addr == 3'b111);
    if (frame_ok && (hit_a || hit_b)) begin
      case (f_cmd)
        3'b000: begin
          if (hit_a) in_a_n = f_data;
          if (hit_b) in_b_n = f_data;
        end
        3'b001: begin
          if (hit_a) dac_a_n = in_a;
          if (hit_b) dac_b_n = in_b;
        end
        3'b010: begin
          if (hit_a) in_a_n = f_data;
          if (hit_b) in_b_n = f_data;
          dac_a_n = in_a_n;
          dac_b_n = in_b_n;
        end
        3'b011: begin
          if (hit_a) begin
            in_a_n  = f_data;
            dac_a_n = f_data;
          end
          if (hit_b) begin
            in_b_n  = f_data;
            dac_b_n = f_data;
          end
        end
        3'b101: begin
          in_a_n  = '0;
          in_b_n  = '0;
          dac_a_n = '0;
          dac_b_n = '0;
        end
        default: ;
      endcase
    end
    if (!ldac_s) begin
      dac_a_n = in_a_n;
      dac_b_n = in_b_n;
    end
    if (!clr_s) begin
      dac_a_n = CLR_VALUE;
      dac_b_n = CLR_VALUE;
    end
  end

  // Registered results: frame pulses, decoded fields and DAC register state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      cmd         <= '0;
      addr        <= '0;
      data        <= '0;
      in_a        <= '0;
      in_b        <= '0;
      DAC_A       <= '0;
      DAC_B       <= '0;
      dac_update  <= 1'b0;
    end else begin
      frame_valid <= frame_ok;
      frame_error <= frame_bad;
      if (frame_ok) begin
        cmd  <= f_cmd;
        addr <= f_addr;
        data <= f_data;
      end
      in_a       <= in_a_n;
      in_b       <= in_b_n;
      DAC_A      <= dac_a_n;
      DAC_B      <= dac_b_n;
      dac_update <= (dac_a_n != DAC_A) || (dac_b_n != DAC_B);
    end
  end

endmodule

// File: tb/tb_audio_dac_frame_receiver.sv
// Testbench for audio_dac_frame_receiver: drives writer-style frames and
// compares against a frame-level model of the DAC register behaviour.
module tb_audio_dac_frame_receiver;

  localparam logic [15:0] CLR_V = 16'h8000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        SCLK = 1'b1, SYNC = 1'b1, DIN = 1'b0, LDAC = 1'b1, CLR = 1'b1;
  logic        frame_valid, frame_error, dac_update, busy;
  logic [2:0]  cmd, addr;
  logic [15:0] data, DAC_A, DAC_B, dbg_in_a, dbg_in_b;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // pulse monitor state
  int fv_cnt = 0, fe_cnt = 0, du_cnt = 0;
  int cyc = 0, fv_cyc = 0, rise_cyc = 0;
  logic busy_mid;

  // reference model
  logic [15:0] m_in_a, m_in_b, m_dac_a, m_dac_b, m_data;
  logic [2:0]  m_cmd, m_addr;

  audio_dac_frame_receiver #(
    .FRAME_BITS(24), .SYNC_STAGES(2), .CLR_VALUE(CLR_V)
  ) dut (
    .clk(clk), .resetn(resetn), .SCLK(SCLK), .SYNC(SYNC), .DIN(DIN),
    .LDAC(LDAC), .CLR(CLR), .frame_valid(frame_valid), .frame_error(frame_error),
    .cmd(cmd), .addr(addr), .data(data), .DAC_A(DAC_A), .DAC_B(DAC_B),
    .dac_update(dac_update), .busy(busy), .dbg_state(dbg_state),
    .dbg_in_a(dbg_in_a), .dbg_in_b(dbg_in_b)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // count output pulses away from the active edge
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt <= fv_cnt + 1;
      fv_cyc <= cyc;
    end
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (dac_update)  du_cnt <= du_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_in_a = '0; m_in_b = '0; m_dac_a = '0; m_dac_b = '0;
    m_cmd = '0; m_addr = '0; m_data = '0;
  endtask

  // frame-level model: applies the whole frame's effect at once
  task automatic model_frame(input logic [23:0] w, input int nbits,
                             output bit valid, output bit upd);
    logic [15:0] old_a, old_b, d;
    logic [2:0]  c, a;
    bit ha, hb;
    old_a = m_dac_a; old_b = m_dac_b;
    valid = (nbits == 24);
    upd = 1'b0;
    if (!valid) return;
    c = w[21:19]; a = w[18:16]; d = w[15:0];
    m_cmd = c; m_addr = a; m_data = d;
    ha = (a == 3'd0) || (a == 3'd7);
    hb = (a == 3'd1) || (a == 3'd7);
    if (ha || hb) begin
      if (c == 3'd0 || c == 3'd2 || c == 3'd3) begin
        if (ha) m_in_a = d;
        if (hb) m_in_b = d;
      end
      if (c == 3'd1) begin
        if (ha) m_dac_a = m_in_a;
        if (hb) m_dac_b = m_in_b;
      end
      if (c == 3'd2) begin
        m_dac_a = m_in_a; m_dac_b = m_in_b;
      end
      if (c == 3'd3) begin
        if (ha) m_dac_a = d;
        if (hb) m_dac_b = d;
      end
      if (c == 3'd5) begin
        m_in_a = '0; m_in_b = '0; m_dac_a = '0; m_dac_b = '0;
      end
    end
    if (!LDAC) begin m_dac_a = m_in_a; m_dac_b = m_in_b; end
    if (!CLR)  begin m_dac_a = CLR_V;  m_dac_b = CLR_V;  end
    upd = (m_dac_a != old_a) || (m_dac_b != old_b);
  endtask

  // one SCLK period: DIN changes with the rise, the receiver samples on the fall
  task automatic drive_bit(input logic b, input int half);
    DIN = b;
    wait_clks(half);
    SCLK = 1'b0;
    wait_clks(half);
    SCLK = 1'b1;
  endtask

  task automatic send_frame(input logic [23:0] w, input int nbits, input int half);
    SYNC = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      drive_bit((i < 24) ? w[23-i] : 1'b0, half);
      if (i == 4) busy_mid = busy;
    end
    wait_clks(half);
    SYNC = 1'b1;
    rise_cyc = cyc;
    wait_clks(10);
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks++;
    if ({frame_valid, frame_error, dac_update, busy} !== 4'b0 || DAC_A !== 16'h0 ||
        DAC_B !== 16'h0 || data !== 16'h0) begin
      errors++;
      $display("FAIL reset_in: pulses/busy=%b DAC_A=%h DAC_B=%h data=%h required all 0",
               {frame_valid, frame_error, dac_update, busy}, DAC_A, DAC_B, data);
    end
    resetn = 1'b1;
    wait_clks(8);
    checks++;
    if (busy !== 1'b0 || DAC_A !== 16'h0 || dbg_in_a !== 16'h0 || dbg_in_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_out: busy=%b DAC_A=%h IN_A=%h IN_B=%h required 0", busy, DAC_A,
               dbg_in_a, dbg_in_b);
    end
  endtask

  task automatic test_basic();
    int fv0, du0;
    bit v, u;
    fv0 = fv_cnt; du0 = du_cnt;
    model_frame({2'b00, 3'b000, 3'b000, 16'h1234}, 24, v, u);
    send_frame({2'b00, 3'b000, 3'b000, 16'h1234}, 24, 1);
    checks++;
    if (fv_cnt - fv0 != 1 || cmd !== 3'b000 || addr !== 3'b000 || data !== 16'h1234) begin
      errors++;
      $display("FAIL basic_f1: valid=%0d cmd=%b addr=%b data=%h required 1 000 000 1234",
               fv_cnt - fv0, cmd, addr, data);
    end
    checks++;
    if (dbg_in_a !== 16'h1234 || DAC_A !== 16'h0 || du_cnt != du0) begin
      errors++;
      $display("FAIL basic_f1_regs: IN_A=%h DAC_A=%h upd=%0d required 1234 0000 0",
               dbg_in_a, DAC_A, du_cnt - du0);
    end
    checks++;
    if (busy_mid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy: mid=%b after=%b required 1 0", busy_mid, busy);
    end
    checks++;
    if (fv_cyc - rise_cyc != 4) begin
      errors++;
      $display("FAIL latency: got %0d clks required 4", fv_cyc - rise_cyc);
    end
    du0 = du_cnt;
    model_frame({2'b11, 3'b010, 3'b001, 16'hABCD}, 24, v, u);
    send_frame({2'b11, 3'b010, 3'b001, 16'hABCD}, 24, 2);
    checks++;
    if (cmd !== 3'b010 || addr !== 3'b001 || data !== 16'hABCD || DAC_A !== 16'h1234 ||
        DAC_B !== 16'hABCD || du_cnt - du0 != 1) begin
      errors++;
      $display("FAIL basic_f2: cmd=%b addr=%b data=%h A=%h B=%h upd=%0d required 010 001 abcd 1234 abcd 1",
               cmd, addr, data, DAC_A, DAC_B, du_cnt - du0);
    end
  endtask

  task automatic test_bad_length();
    int fv0, fe0;
    bit v, u;
    int lens[2] = '{10, 25};
    for (int k = 0; k < 2; k++) begin
      fv0 = fv_cnt; fe0 = fe_cnt;
      model_frame({2'b00, 3'b011, 3'b111, 16'hFFFF}, lens[k], v, u);
      send_frame({2'b00, 3'b011, 3'b111, 16'hFFFF}, lens[k], 1);
      checks++;
      if (fe_cnt - fe0 != 1 || fv_cnt != fv0 || DAC_A !== m_dac_a || DAC_B !== m_dac_b ||
          dbg_in_a !== m_in_a || dbg_in_b !== m_in_b) begin
        errors++;
        $display("FAIL bad_len_%0d: err=%0d valid=%0d A=%h B=%h required 1 0 %h %h",
                 lens[k], fe_cnt - fe0, fv_cnt - fv0, DAC_A, DAC_B, m_dac_a, m_dac_b);
      end
    end
  endtask

  task automatic test_clr_ldac();
    int du0;
    bit v, u;
    CLR = 1'b0;
    m_dac_a = CLR_V; m_dac_b = CLR_V;
    wait_clks(6);
    checks++;
    if (DAC_A !== CLR_V || DAC_B !== CLR_V) begin
      errors++;
      $display("FAIL clr_hold: A=%h B=%h required %h", DAC_A, DAC_B, CLR_V);
    end
    du0 = du_cnt;
    model_frame({2'b00, 3'b011, 3'b111, 16'h5555}, 24, v, u);
    send_frame({2'b00, 3'b011, 3'b111, 16'h5555}, 24, 2);
    checks++;
    if (DAC_A !== 16'h8000 || DAC_B !== 16'h8000 || dbg_in_a !== 16'h5555 ||
        dbg_in_b !== 16'h5555 || du_cnt != du0) begin
      errors++;
      $display("FAIL clr_frame: A=%h B=%h IN_A=%h IN_B=%h upd=%0d required 8000 8000 5555 5555 0",
               DAC_A, DAC_B, dbg_in_a, dbg_in_b, du_cnt - du0);
    end
    LDAC = 1'b0;
    wait_clks(6);
    du0 = du_cnt;
    CLR = 1'b1;
    m_dac_a = m_in_a; m_dac_b = m_in_b;
    wait_clks(6);
    checks++;
    if (DAC_A !== 16'h5555 || DAC_B !== 16'h5555 || du_cnt - du0 != 1) begin
      errors++;
      $display("FAIL clr_release: A=%h B=%h upd=%0d required 5555 5555 1", DAC_A, DAC_B,
               du_cnt - du0);
    end
    LDAC = 1'b1;
    wait_clks(6);
  endtask

  task automatic test_clear_cmd();
    int du0;
    bit v, u;
    model_frame({2'b00, 3'b011, 3'b000, 16'h0F0F}, 24, v, u);
    send_frame({2'b00, 3'b011, 3'b000, 16'h0F0F}, 24, 1);
    du0 = du_cnt;
    model_frame({2'b00, 3'b101, 3'b111, 16'h0000}, 24, v, u);
    send_frame({2'b00, 3'b101, 3'b111, 16'h0000}, 24, 1);
    checks++;
    if (DAC_A !== 16'h0 || DAC_B !== 16'h0 || dbg_in_a !== 16'h0 || dbg_in_b !== 16'h0 ||
        du_cnt - du0 != 1) begin
      errors++;
      $display("FAIL clear_cmd: A=%h B=%h IN_A=%h IN_B=%h upd=%0d required 0 0 0 0 1",
               DAC_A, DAC_B, dbg_in_a, dbg_in_b, du_cnt - du0);
    end
  endtask

  task automatic test_reset_midframe();
    int fv0, fe0;
    logic [23:0] w;
    bit v, u;
    model_frame({2'b00, 3'b011, 3'b111, 16'h2222}, 24, v, u);
    send_frame({2'b00, 3'b011, 3'b111, 16'h2222}, 24, 1);
    fv0 = fv_cnt; fe0 = fe_cnt;
    SYNC = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(1'b1, 1);
    resetn = 1'b0;
    model_reset();
    wait_clks(2);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) drive_bit(i[0], 1);
    wait_clks(1);
    SYNC = 1'b1;
    wait_clks(10);
    checks++;
    if (fv_cnt != fv0 || fe_cnt != fe0 || DAC_A !== 16'h0 || DAC_B !== 16'h0 ||
        data !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0d err=%0d A=%h B=%h data=%h required 0 0 0 0 0",
               fv_cnt - fv0, fe_cnt - fe0, DAC_A, DAC_B, data);
    end
    w = {2'b01, 3'b011, 3'b001, 16'($urandom)};
    model_frame(w, 24, v, u);
    send_frame(w, 24, 2);
    checks++;
    if (fv_cnt - fv0 != 1 || DAC_B !== m_dac_b || data !== m_data) begin
      errors++;
      $display("FAIL after_reset: valid=%0d B=%h data=%h required 1 %h %h",
               fv_cnt - fv0, DAC_B, data, m_dac_b, m_data);
    end
  endtask

  task automatic test_invalid_addr();
    int fv0, du0;
    bit v, u;
    logic [23:0] w;
    fv0 = fv_cnt; du0 = du_cnt;
    w = {2'b00, 3'b011, 3'b011, 16'($urandom)};
    model_frame(w, 24, v, u);
    send_frame(w, 24, 1);
    checks++;
    if (fv_cnt - fv0 != 1 || du_cnt != du0 || addr !== 3'b011 || DAC_A !== m_dac_a ||
        DAC_B !== m_dac_b || dbg_in_a !== m_in_a || dbg_in_b !== m_in_b) begin
      errors++;
      $display("FAIL invalid_addr: valid=%0d upd=%0d addr=%b A=%h B=%h required 1 0 011 %h %h",
               fv_cnt - fv0, du_cnt - du0, addr, DAC_A, DAC_B, m_dac_a, m_dac_b);
    end
  endtask

  task automatic test_random();
    int fv0, fe0, du0, nb, half;
    logic [2:0] c, a;
    logic [23:0] w;
    bit v, u;
    logic [2:0] addr_pool[4] = '{3'd0, 3'd1, 3'd7, 3'd4};
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        LDAC = ~LDAC;
        if (!LDAC) begin m_dac_a = m_in_a; m_dac_b = m_in_b; end
        wait_clks(6);
      end
      c = 3'($urandom_range(0, 7));
      a = addr_pool[$urandom_range(0, 3)];
      w = {2'($urandom), c, a, 16'($urandom)};
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 28) : 24;
      half = $urandom_range(1, 3);
      fv0 = fv_cnt; fe0 = fe_cnt; du0 = du_cnt;
      model_frame(w, nb, v, u);
      send_frame(w, nb, half);
      checks++;
      if (fv_cnt - fv0 != int'(v) || fe_cnt - fe0 != int'(!v) || du_cnt - du0 != int'(u)) begin
        errors++;
        $display("FAIL rand_pulses[%0d]: valid=%0d err=%0d upd=%0d required %0d %0d %0d",
                 k, fv_cnt - fv0, fe_cnt - fe0, du_cnt - du0, v, !v, u);
      end
      checks++;
      if (DAC_A !== m_dac_a || DAC_B !== m_dac_b || dbg_in_a !== m_in_a ||
          dbg_in_b !== m_in_b || cmd !== m_cmd || addr !== m_addr || data !== m_data) begin
        errors++;
        $display("FAIL rand_regs[%0d]: A=%h B=%h IN=%h/%h f=%b/%b/%h required %h %h %h/%h %b/%b/%h",
                 k, DAC_A, DAC_B, dbg_in_a, dbg_in_b, cmd, addr, data,
                 m_dac_a, m_dac_b, m_in_a, m_in_b, m_cmd, m_addr, m_data);
      end
    end
    LDAC = 1'b1;
    wait_clks(6);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_bad_length();
    test_clr_ldac();
    test_clear_cmd();
    test_reset_midframe();
    test_invalid_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
